lfsr_sync_checker: RTL and testbench

- Receive-side PRBS monitor for the 8-bit LFSR stream driven by LFSR_generator.
- Self-seeds from the incoming stream and verifies a run of predicted values before declaring lock.
- Once locked, flywheels on its own prediction, counts bit-word errors and drops lock after a run of consecutive misses.
- Sits alongside LFSR_Checker in the link bench and top level; adds resync and error statistics.

---
 rtl/lfsr_pkg.sv | 24 ++
 rtl/lfsr_step.sv | 14 +
 rtl/lfsr_sync_checker.sv | 162 ++++++++++++++++
 tb/tb_lfsr_sync_checker.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit PRBS generator and its receive-side checkers.
// Holds the stream width, default feedback taps, checker states and the step function.
package lfsr_pkg;

    localparam int LFSR_W = 8;

    // x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [LFSR_W-1:0] DEF_TAPS = 8'b1011_1000;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2,
        RSVD   = 2'd3
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] q,
        input logic [LFSR_W-1:0] taps
    );
        return {q[LFSR_W-2:0], ^(q & taps)};
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single-step advance of the PRBS register.
// Used for both the seed path and the flywheel path of the checker.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] TAPS = DEF_TAPS
) (
    input  logic [LFSR_W-1:0] i_q,
    output logic [LFSR_W-1:0] o_next
);

    assign o_next = lfsr_next(i_q, TAPS);

endmodule

// File: rtl/lfsr_sync_checker.sv
// Receive-side PRBS monitor: seeds from the stream, verifies, then flywheels.
// Counts mismatching words while locked and re-hunts after a run of misses.
module lfsr_sync_checker
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] TAPS       = DEF_TAPS,
    parameter int                LOCK_CNT   = 4,
    parameter int                UNLOCK_CNT = 3,
    parameter int                ERR_W      = 16
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_soft_reset,
    input  logic              i_valid,
    input  logic [LFSR_W-1:0] i_LFSR,
    input  logic              i_clear_counts,
    output logic              o_lock,
    output logic              o_err,
    output logic [ERR_W-1:0]  o_err_count,
    output logic [1:0]        o_state
);

    localparam logic [3:0] LOCK_LAST   = 4'(LOCK_CNT - 1);
    localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_CNT - 1);

    state_t             r_state;
    logic [LFSR_W-1:0]  r_pred;
    logic [3:0]         r_match;
    logic [3:0]         r_miss;
    logic               r_lock;
    logic               r_err;
    logic [ERR_W-1:0]   r_err_count;

    state_t             w_state_nx;
    logic [LFSR_W-1:0]  w_pred_nx;
    logic [3:0]         w_match_nx;
    logic [3:0]         w_miss_nx;
    logic               w_lock_nx;
    logic               w_err_nx;
    logic [ERR_W-1:0]   w_cnt_nx;
    logic               w_inc;

    logic [LFSR_W-1:0]  w_seed_nx;
    logic [LFSR_W-1:0]  w_fly_nx;
    logic               w_hit;
    logic               w_zero;

    lfsr_step #(.TAPS(TAPS)) u_seed (
        .i_q    (i_LFSR),
        .o_next (w_seed_nx)
    );

    lfsr_step #(.TAPS(TAPS)) u_fly (
        .i_q    (r_pred),
        .o_next (w_fly_nx)
    );

    assign w_hit  = (i_LFSR == r_pred);
    assign w_zero = (i_LFSR == '0);

    always_comb begin
        w_state_nx = r_state;
        w_pred_nx  = r_pred;
        w_match_nx = r_match;
        w_miss_nx  = r_miss;
        w_lock_nx  = r_lock;
        w_err_nx   = 1'b0;
        w_inc      = 1'b0;

        if (i_soft_reset || r_state == RSVD) begin
            w_state_nx = HUNT;
            w_pred_nx  = '0;
            w_match_nx = '0;
            w_miss_nx  = '0;
            w_lock_nx  = 1'b0;
        end else if (i_valid) begin
            unique case (r_state)
                HUNT: begin
                    if (!w_zero) begin
                        w_state_nx = VERIFY;
                        w_pred_nx  = w_seed_nx;
                        w_match_nx = '0;
                    end
                end
                VERIFY: begin
                    if (w_hit) begin
                        w_pred_nx = w_seed_nx;
                        if (r_match == LOCK_LAST) begin
                            w_state_nx = LOCKED;
                            w_lock_nx  = 1'b1;
                            w_match_nx = '0;
                            w_miss_nx  = '0;
                        end else begin
                            w_match_nx = r_match + 4'd1;
                        end
                    end else if (!w_zero) begin
                        w_pred_nx  = w_seed_nx;
                        w_match_nx = '0;
                    end else begin
                        w_state_nx = HUNT;
                        w_pred_nx  = '0;
                        w_match_nx = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: advance on every valid word, good or bad
                    w_pred_nx = w_fly_nx;
                    if (w_hit) begin
                        w_miss_nx = '0;
                    end else begin
                        w_err_nx = 1'b1;
                        w_inc    = 1'b1;
                        if (r_miss == UNLOCK_LAST) begin
                            w_state_nx = HUNT;
                            w_lock_nx  = 1'b0;
                            w_miss_nx  = '0;
                            w_pred_nx  = '0;
                        end else begin
                            w_miss_nx = r_miss + 4'd1;
                        end
                    end
                end
                default: begin
                    w_state_nx = HUNT;
                end
            endcase
        end

        w_cnt_nx = r_err_count;
        if (i_clear_counts) begin
            w_cnt_nx = '0;
        end else if (w_inc && r_err_count != '1) begin
            w_cnt_nx = r_err_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state     <= HUNT;
            r_pred      <= '0;
            r_match     <= '0;
            r_miss      <= '0;
            r_lock      <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_pred      <= w_pred_nx;
            r_match     <= w_match_nx;
            r_miss      <= w_miss_nx;
            r_lock      <= w_lock_nx;
            r_err       <= w_err_nx;
            r_err_count <= w_cnt_nx;
        end
    end

    assign o_lock      = r_lock;
    assign o_err       = r_err;
    assign o_err_count = r_err_count;
    assign o_state     = r_state;

endmodule

// File: tb/tb_lfsr_sync_checker.sv
// Directed self-checking bench for lfsr_sync_checker.
// Stream words from seed FF: FF FE FC F8 F0 E1 C2 85 0B 17 2F 5E BC 78 F1 E3.
module tb_lfsr_sync_checker;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_soft_reset;
    logic        i_valid;
    logic [7:0]  i_LFSR;
    logic        i_clear_counts;
    logic        o_lock;
    logic        o_err;
    logic [15:0] o_err_count;
    logic [1:0]  o_state;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lfsr_sync_checker dut (
        .clk            (clk),
        .i_rst          (i_rst),
        .i_soft_reset   (i_soft_reset),
        .i_valid        (i_valid),
        .i_LFSR         (i_LFSR),
        .i_clear_counts (i_clear_counts),
        .o_lock         (o_lock),
        .o_err          (o_err),
        .o_err_count    (o_err_count),
        .o_state        (o_state)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, then sample 1ns after the rising edge
    task automatic cyc(input logic v, input logic [7:0] d,
                       input logic sr = 1'b0, input logic cc = 1'b0);
        i_valid        = v;
        i_LFSR         = d;
        i_soft_reset   = sr;
        i_clear_counts = cc;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic lk,
                              input logic er, input logic [15:0] cnt,
                              input logic [1:0] st);
        chk({tag, ".lock"}, 32'(o_lock), 32'(lk));
        chk({tag, ".err"}, 32'(o_err), 32'(er));
        chk({tag, ".cnt"}, 32'(o_err_count), 32'(cnt));
        chk({tag, ".state"}, 32'(o_state), 32'(st));
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'hFF);
        i_rst = 1'b0;
    endtask

    logic [7:0] seq [16] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1,
                             8'hC2, 8'h85, 8'h0B, 8'h17, 8'h2F, 8'h5E,
                             8'hBC, 8'h78, 8'hF1, 8'hE3};

    initial begin
        i_rst = 1'b1; i_soft_reset = 1'b0; i_valid = 1'b0;
        i_LFSR = 8'h00; i_clear_counts = 1'b0;

        // Reset state
        do_reset();
        expect_out("rst", 1'b0, 1'b0, 16'd0, 2'd0);

        // Clean stream: lock one cycle after F0
        cyc(1'b1, seq[0]);
        expect_out("t1.seed", 1'b0, 1'b0, 16'd0, 2'd1);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, seq[i]);
            expect_out($sformatf("t1.m%0d", i), 1'b0, 1'b0, 16'd0, 2'd1);
        end
        cyc(1'b1, seq[4]);
        expect_out("t1.lock", 1'b1, 1'b0, 16'd0, 2'd2);

        // Single corrupted word while locked
        cyc(1'b1, 8'h00);
        expect_out("t2.bad", 1'b1, 1'b1, 16'd1, 2'd2);
        cyc(1'b1, seq[6]);
        expect_out("t2.fly1", 1'b1, 1'b0, 16'd1, 2'd2);
        cyc(1'b1, seq[7]);
        expect_out("t2.fly2", 1'b1, 1'b0, 16'd1, 2'd2);

        // Clear with no valid, then three misses drop lock
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        expect_out("t3.clr", 1'b1, 1'b0, 16'd0, 2'd2);
        cyc(1'b1, 8'h00);
        expect_out("t3.e1", 1'b1, 1'b1, 16'd1, 2'd2);
        cyc(1'b1, 8'h00);
        expect_out("t3.e2", 1'b1, 1'b1, 16'd2, 2'd2);
        cyc(1'b1, 8'h00);
        expect_out("t3.e3", 1'b0, 1'b1, 16'd3, 2'd0);
        cyc(1'b1, seq[11]);
        expect_out("t3.seed", 1'b0, 1'b0, 16'd3, 2'd1);
        for (int i = 12; i <= 14; i++) begin
            cyc(1'b1, seq[i]);
            expect_out($sformatf("t3.m%0d", i), 1'b0, 1'b0, 16'd3, 2'd1);
        end
        cyc(1'b1, seq[15]);
        expect_out("t3.relock", 1'b1, 1'b0, 16'd3, 2'd2);

        // Zero words from reset never seed
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'h00);
            expect_out($sformatf("t4.z%0d", i), 1'b0, 1'b0, 16'd0, 2'd0);
        end

        // Gapped clean stream: lock after 5 valid words
        do_reset();
        cyc(1'b1, seq[0]);
        expect_out("t5.seed", 1'b0, 1'b0, 16'd0, 2'd1);
        cyc(1'b0, 8'h55);
        expect_out("t5.gap1", 1'b0, 1'b0, 16'd0, 2'd1);
        cyc(1'b0, 8'h00);
        expect_out("t5.gap2", 1'b0, 1'b0, 16'd0, 2'd1);
        cyc(1'b1, seq[1]);
        cyc(1'b1, seq[2]);
        cyc(1'b0, 8'hAA);
        expect_out("t5.gap3", 1'b0, 1'b0, 16'd0, 2'd1);
        cyc(1'b1, seq[3]);
        expect_out("t5.m3", 1'b0, 1'b0, 16'd0, 2'd1);
        cyc(1'b0, 8'h12);
        expect_out("t5.gap4", 1'b0, 1'b0, 16'd0, 2'd1);
        cyc(1'b1, seq[4]);
        expect_out("t5.lock", 1'b1, 1'b0, 16'd0, 2'd2);
        cyc(1'b0, 8'h00);
        expect_out("t5.gapL", 1'b1, 1'b0, 16'd0, 2'd2);
        cyc(1'b0, 8'h33);
        expect_out("t5.gapL2", 1'b1, 1'b0, 16'd0, 2'd2);

        // Two errors, a good word, then soft reset keeps the count
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h00);
        expect_out("t6.e2", 1'b1, 1'b1, 16'd2, 2'd2);
        cyc(1'b1, seq[7]);
        expect_out("t6.good", 1'b1, 1'b0, 16'd2, 2'd2);
        cyc(1'b1, 8'h00, 1'b1, 1'b0);
        expect_out("t6.soft", 1'b0, 1'b0, 16'd2, 2'd0);
        for (int i = 0; i <= 4; i++) cyc(1'b1, seq[i]);
        expect_out("t6.relock", 1'b1, 1'b0, 16'd2, 2'd2);
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        expect_out("t6.clr_err", 1'b1, 1'b1, 16'd0, 2'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
